// File: rtl/pkt_rr_scheduler.sv
// Packet-granular round-robin scheduler that shares one 2-phase req/ack channel
// among N_SRC synchronous sources; a grant is held from first word to tail word.
module pkt_rr_scheduler #(
  parameter int N_SRC       = 4,
  parameter int WORD_WIDTH  = 32,
  parameter int TAIL_BIT    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_SRC-1:0]              src_valid,
  input  logic [N_SRC*WORD_WIDTH-1:0]   src_data,
  output logic [N_SRC-1:0]              src_ready,
  output logic                          out_req,
  input  logic                          out_ack,
  output logic [WORD_WIDTH-1:0]         out_data,
  output logic [$clog2(N_SRC)-1:0]      grant_id,
  output logic                          busy,
  output logic [31:0]                   pkt_count,
  output logic                          proto_err
);

  localparam int IDW = $clog2(N_SRC);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    WAIT
  } state_t;

  state_t                  state;
  state_t                  state_d;
  logic [IDW-1:0]          rr_ptr;
  logic [SYNC_STAGES-1:0]  ack_sync;
  logic                    ack_s;
  logic                    ack_done;
  logic                    tail_r;
  logic                    pick_found;
  logic [IDW-1:0]          pick_idx;
  logic [WORD_WIDTH-1:0]   sel_word;
  logic                    fetch_hs;

  // Modular increment by compare so non-power-of-2 source counts wrap correctly.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_SRC) sum = sum - N_SRC;
    return sum[IDW-1:0];
  endfunction

  assign ack_s    = ack_sync[SYNC_STAGES-1];
  assign ack_done = (ack_s == out_req);
  assign fetch_hs = (state == FETCH) && src_valid[grant_id];

  // Search rr_ptr, rr_ptr+1, ...; descending walk lets the nearest candidate win.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (src_valid[wrap_add(rr_ptr, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(rr_ptr, k);
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_id == IDW'(i)) sel_word = src_data[i*WORD_WIDTH +: WORD_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d   = state;
    src_ready = '0;
    case (state)
      IDLE: begin
        if (pick_found) state_d = FETCH;
      end
      FETCH: begin
        src_ready[grant_id] = src_valid[grant_id];
        if (src_valid[grant_id]) state_d = SEND;
      end
      SEND: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (ack_done) state_d = tail_r ? IDLE : FETCH;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The ack is asynchronous; only the last synchroniser stage is ever compared.
  always_ff @(posedge clk) begin
    if (reset) ack_sync <= '0;
    else       ack_sync <= {ack_sync[SYNC_STAGES-2:0], out_ack};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_req   <= 1'b0;
      out_data  <= '0;
      tail_r    <= 1'b0;
      grant_id  <= '0;
      busy      <= 1'b0;
      rr_ptr    <= '0;
      pkt_count <= '0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          if (fetch_hs) begin
            out_data <= sel_word;
            tail_r   <= sel_word[TAIL_BIT];
          end
        end
        SEND: begin
          out_req <= ~out_req;
        end
        WAIT: begin
          if (ack_done && tail_r) begin
            pkt_count <= pkt_count + 32'd1;
            rr_ptr    <= wrap_add(grant_id, 1);
            busy      <= 1'b0;
          end
        end
        default: begin
        end
      endcase
      // Outside WAIT the ack must already match the request phase.
      if (!ack_done && state != WAIT) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pkt_rr_scheduler.sv
// Directed bench for pkt_rr_scheduler: word-queue sources, echoing 2-phase ack,
// and a monitor that logs every word offered on an out_req toggle.
module tb_pkt_rr_scheduler;

  localparam int NS = 4;
  localparam int WW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NS-1:0]   src_valid = '0;
  logic [NS*WW-1:0] src_data = '0;
  logic [NS-1:0]   src_ready;
  logic            out_req;
  logic            out_ack = 1'b0;
  logic [WW-1:0]   out_data;
  logic [1:0]      grant_id;
  logic            busy;
  logic [31:0]     pkt_count;
  logic            proto_err;

  int tests = 0;
  int fails = 0;

  logic [31:0] words [NS][16];
  int          head [NS];
  int          cnt [NS];
  logic [NS-1:0] pop_pend = '0;
  bit          ack_auto = 1'b1;

  logic [31:0] obs [64];
  logic [1:0]  obs_gid [64];
  int          nobs = 0;
  logic        prev_req = 1'b0;

  pkt_rr_scheduler #(
    .N_SRC(NS), .WORD_WIDTH(WW), .TAIL_BIT(1), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .out_req(out_req), .out_ack(out_ack),
    .out_data(out_data), .grant_id(grant_id), .busy(busy),
    .pkt_count(pkt_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Sources: pop words handshaken at the previous edge, then present the next word.
  always begin
    @(negedge clk);
    for (int i = 0; i < NS; i++) if (pop_pend[i]) head[i]++;
    for (int i = 0; i < NS; i++) begin
      src_valid[i] = head[i] < cnt[i];
      src_data[i*WW +: WW] = (head[i] < cnt[i]) ? words[i][head[i]] : 32'h0;
    end
    #1;
    pop_pend = reset ? '0 : (src_valid & src_ready);
  end

  // Downstream pipeline: echo each request phase back after 5 ns.
  always begin
    @(out_req);
    if (ack_auto) begin
      #5;
      out_ack = out_req;
    end
  end

  always @(negedge clk) begin
    if (out_req !== prev_req) begin
      if (nobs < 64) begin
        obs[nobs]     = out_data;
        obs_gid[nobs] = grant_id;
        nobs++;
      end
      prev_req = out_req;
    end
  end

  task automatic clear_queues();
    for (int i = 0; i < NS; i++) begin
      head[i] = 0;
      cnt[i]  = 0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset    = 1'b1;
    out_ack  = 1'b0;
    ack_auto = 1'b1;
    @(negedge clk);
    clear_queues();
    @(negedge clk);
    reset = 1'b0;
    nobs  = 0;
  endtask

  task automatic wait_done(output bit ok);
    bool_loop: begin
      ok = 1'b0;
      for (int c = 0; c < 800; c++) begin
        bit drained;
        @(negedge clk);
        drained = 1'b1;
        for (int i = 0; i < NS; i++) if (head[i] < cnt[i]) drained = 1'b0;
        if (drained && !busy && out_ack === out_req) begin
          ok = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic wait_toggles(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (nobs >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    words[0][0] = 32'h10;
    cnt[0] = 1;
    head[0] = 0;
    repeat (3) @(negedge clk);
    tests++;
    if (out_req !== 1'b0 || out_data !== 32'h0 || grant_id !== 2'd0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got req=%b data=%h gid=%0d busy=%b, expected 0/0/0/0",
               out_req, out_data, grant_id, busy);
    end
    tests++;
    if (pkt_count !== 32'd0 || proto_err !== 1'b0 || src_ready !== 4'b0) begin
      fails++;
      $display("[TB] FAIL reset_counters: got cnt=%0d perr=%b ready=%b, expected 0/0/0000",
               pkt_count, proto_err, src_ready);
    end
    clear_queues();
    @(negedge clk);
    reset = 1'b0;
    nobs  = 0;
  endtask

  task automatic test_single_source();
    bit ok;
    logic [31:0] exp_w [3] = '{32'h10, 32'h20, 32'h06};
    apply_reset();
    words[0][0] = 32'h10;
    words[0][1] = 32'h20;
    words[0][2] = 32'h06;
    cnt[0] = 3;
    wait_done(ok);
    tests++;
    if (!ok || nobs !== 3) begin
      fails++;
      $display("[TB] FAIL single_toggles: got done=%b toggles=%0d, expected 1/3", ok, nobs);
    end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (obs[k] !== exp_w[k]) begin
        fails++;
        $display("[TB] FAIL single_word%0d: got %h expected %h", k, obs[k], exp_w[k]);
      end
    end
    tests++;
    if (pkt_count !== 32'd1 || grant_id !== 2'd0 || busy !== 1'b0 || proto_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_status: got cnt=%0d gid=%0d busy=%b perr=%b, expected 1/0/0/0",
               pkt_count, grant_id, busy, proto_err);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [31:0] exp_w [10] = '{32'h000, 32'h002, 32'h100, 32'h102, 32'h200,
                                32'h202, 32'h300, 32'h302, 32'h010, 32'h012};
    logic [1:0]  exp_g [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    apply_reset();
    for (int s = 0; s < NS; s++) begin
      words[s][0] = 32'(s) << 8;
      words[s][1] = (32'(s) << 8) | 32'h2;
      cnt[s] = 2;
    end
    words[0][2] = 32'h010;
    words[0][3] = 32'h012;
    cnt[0] = 4;
    wait_done(ok);
    tests++;
    if (!ok || nobs !== 10) begin
      fails++;
      $display("[TB] FAIL rr_toggles: got done=%b toggles=%0d, expected 1/10", ok, nobs);
    end
    for (int k = 0; k < 10; k++) begin
      tests++;
      if (obs[k] !== exp_w[k] || obs_gid[k] !== exp_g[k]) begin
        fails++;
        $display("[TB] FAIL rr_word%0d: got %h gid %0d expected %h gid %0d",
                 k, obs[k], obs_gid[k], exp_w[k], exp_g[k]);
      end
    end
    tests++;
    if (pkt_count !== 32'd5) begin
      fails++;
      $display("[TB] FAIL rr_pkt_count: got %0d expected 5", pkt_count);
    end
  endtask

  task automatic test_hold_grant();
    bit ok;
    int viol = 0;
    logic [31:0] exp_w [3] = '{32'h200, 32'h202, 32'h102};
    logic [1:0]  exp_g [3] = '{2'd2, 2'd2, 2'd1};
    apply_reset();
    words[2][0] = 32'h200;
    cnt[2] = 1;
    wait_toggles(1, ok);
    words[1][0] = 32'h102;
    cnt[1] = 1;
    repeat (20) begin
      @(negedge clk);
      if (grant_id !== 2'd2 || src_ready[1] !== 1'b0 || busy !== 1'b1) viol++;
    end
    tests++;
    if (!ok || viol != 0) begin
      fails++;
      $display("[TB] FAIL hold_grant: got first=%b violations=%0d, expected 1/0", ok, viol);
    end
    words[2][1] = 32'h202;
    cnt[2] = 2;
    wait_done(ok);
    tests++;
    if (!ok || nobs !== 3) begin
      fails++;
      $display("[TB] FAIL hold_toggles: got done=%b toggles=%0d, expected 1/3", ok, nobs);
    end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (obs[k] !== exp_w[k] || obs_gid[k] !== exp_g[k]) begin
        fails++;
        $display("[TB] FAIL hold_word%0d: got %h gid %0d expected %h gid %0d",
                 k, obs[k], obs_gid[k], exp_w[k], exp_g[k]);
      end
    end
    tests++;
    if (pkt_count !== 32'd2) begin
      fails++;
      $display("[TB] FAIL hold_pkt_count: got %0d expected 2", pkt_count);
    end
  endtask

  task automatic test_ack_hold();
    bit ok;
    int viol = 0;
    apply_reset();
    ack_auto = 1'b0;
    words[0][0] = 32'h30;
    words[0][1] = 32'h32;
    cnt[0] = 2;
    wait_toggles(1, ok);
    repeat (40) begin
      @(negedge clk);
      if (out_data !== 32'h30 || out_req !== 1'b1 || src_ready !== 4'b0) viol++;
    end
    tests++;
    if (!ok || viol != 0) begin
      fails++;
      $display("[TB] FAIL ack_hold: got first=%b violations=%0d, expected 1/0", ok, viol);
    end
    ack_auto = 1'b1;
    out_ack  = 1'b1;
    wait_done(ok);
    tests++;
    if (!ok || nobs !== 2 || obs[1] !== 32'h32 || pkt_count !== 32'd1) begin
      fails++;
      $display("[TB] FAIL ack_release: got done=%b toggles=%0d word=%h cnt=%0d, expected 1/2/32/1",
               ok, nobs, obs[1], pkt_count);
    end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    apply_reset();
    ack_auto = 1'b0;
    words[0][0] = 32'h40;
    words[0][1] = 32'h50;
    words[0][2] = 32'h42;
    cnt[0] = 3;
    wait_toggles(1, ok);
    repeat (2) @(negedge clk);
    reset   = 1'b1;
    out_ack = 1'b0;
    @(negedge clk);
    tests++;
    if (!ok || out_req !== 1'b0 || pkt_count !== 32'd0 || busy !== 1'b0 || src_ready !== 4'b0) begin
      fails++;
      $display("[TB] FAIL midreset_state: got first=%b req=%b cnt=%0d busy=%b ready=%b, expected 1/0/0/0/0000",
               ok, out_req, pkt_count, busy, src_ready);
    end
    clear_queues();
    reset = 1'b0;
    @(negedge clk);
    nobs = 0;
    ack_auto = 1'b1;
    words[1][0] = 32'h60;
    words[1][1] = 32'h62;
    cnt[1] = 2;
    wait_done(ok);
    tests++;
    if (!ok || nobs !== 2 || obs[0] !== 32'h60 || obs[1] !== 32'h62) begin
      fails++;
      $display("[TB] FAIL midreset_fresh: got done=%b toggles=%0d words=%h,%h, expected 1/2/60,62",
               ok, nobs, obs[0], obs[1]);
    end
    tests++;
    if (pkt_count !== 32'd1 || grant_id !== 2'd1 || proto_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_status: got cnt=%0d gid=%0d perr=%b, expected 1/1/0",
               pkt_count, grant_id, proto_err);
    end
  endtask

  task automatic test_proto_err();
    apply_reset();
    ack_auto = 1'b0;
    @(negedge clk);
    out_ack = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (proto_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL perr_early: got %b expected 0", proto_err);
    end
    @(negedge clk);
    tests++;
    if (proto_err !== 1'b1) begin
      fails++;
      $display("[TB] FAIL perr_set: got %b expected 1", proto_err);
    end
    out_ack = 1'b0;
    repeat (10) @(negedge clk);
    tests++;
    if (proto_err !== 1'b1) begin
      fails++;
      $display("[TB] FAIL perr_sticky: got %b expected 1", proto_err);
    end
    apply_reset();
    tests++;
    if (proto_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL perr_cleared: got %b expected 0", proto_err);
    end
  endtask

  initial begin
    clear_queues();
    test_reset();
    test_single_source();
    test_round_robin();
    test_hold_grant();
    test_ack_hold();
    test_reset_mid_packet();
    test_proto_err();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within 50000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
